// File: rtl/imem_loader.sv
// Serial boot loader: parses a framed byte stream and writes the program image into
// instruction memory, holding the core in reset until a frame completes with a good checksum.
module imem_loader #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 24
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic [7:0]        iw_byte,
    input  logic              iw_byte_valid,
    output logic              ow_byte_ready,
    input  logic              iw_abort,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    output logic              ow_cpu_hold,
    output logic              ow_done,
    output logic              ow_err,
    output logic              or_busy
);

    localparam int ABYTES = ADDR_W / 8;
    localparam int DBYTES = DATA_W / 8;
    localparam logic [7:0] ALAST = 8'(ABYTES - 1);
    localparam logic [7:0] DLAST = 8'(DBYTES - 1);
    localparam logic [7:0] SYNC  = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HADDR,
        HCNT,
        DATA,
        WRITE,
        CSUM
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rdy;
    logic [7:0]        r_bcnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [15:0]       r_remain;
    logic [7:0]        r_csum;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_hold;
    logic              r_done;
    logic              r_err;

    logic              w_abort;
    logic              w_acc;
    logic              w_we;
    logic [15:0]       w_cnt_next;

    assign w_abort    = iw_abort && (r_state != IDLE);
    assign w_acc      = iw_byte_valid && ow_byte_ready && !w_abort;
    assign w_we       = (r_state == WRITE) && !w_abort;
    assign w_cnt_next = {r_remain[7:0], iw_byte};

    // r_rdy keeps ready low throughout reset and lets it rise on the first edge after release
    assign ow_byte_ready = r_rdy && (r_state != WRITE);
    assign ow_mem_we     = w_we;
    assign ow_mem_addr   = w_we ? r_addr : r_mem_addr;
    assign ow_mem_wdata  = w_we ? r_data : r_mem_wdata;
    assign ow_cpu_hold   = r_hold;
    assign ow_done       = r_done;
    assign ow_err        = r_err;
    assign or_busy       = (r_state != IDLE);

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (w_acc && iw_byte == SYNC) w_next = HADDR;
                HADDR: if (w_acc && r_bcnt == ALAST) w_next = HCNT;
                HCNT:  if (w_acc && r_bcnt == 8'd1) w_next = (w_cnt_next != 16'd0) ? DATA : CSUM;
                DATA:  if (w_acc && r_bcnt == DLAST) w_next = WRITE;
                WRITE: w_next = (r_remain != 16'd1) ? DATA : CSUM;
                CSUM:  if (w_acc) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_rdy       <= 1'b0;
            r_bcnt      <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_remain    <= '0;
            r_csum      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hold      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rdy  <= 1'b1;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_abort) begin
                r_err  <= 1'b1;
                r_bcnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_acc && iw_byte == SYNC) begin
                            r_csum <= '0;
                            r_bcnt <= '0;
                            r_hold <= 1'b1;
                        end
                    end
                    HADDR: begin
                        if (w_acc) begin
                            r_addr <= (r_addr << 8) | ADDR_W'(iw_byte);
                            r_csum <= r_csum + iw_byte;
                            r_bcnt <= (r_bcnt == ALAST) ? 8'd0 : r_bcnt + 8'd1;
                        end
                    end
                    HCNT: begin
                        if (w_acc) begin
                            r_remain <= w_cnt_next;
                            r_csum   <= r_csum + iw_byte;
                            r_bcnt   <= (r_bcnt == 8'd1) ? 8'd0 : r_bcnt + 8'd1;
                        end
                    end
                    DATA: begin
                        if (w_acc) begin
                            r_data <= (r_data << 8) | DATA_W'(iw_byte);
                            r_csum <= r_csum + iw_byte;
                            r_bcnt <= (r_bcnt == DLAST) ? 8'd0 : r_bcnt + 8'd1;
                        end
                    end
                    WRITE: begin
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_data;
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_remain    <= r_remain - 16'd1;
                    end
                    CSUM: begin
                        if (w_acc) begin
                            if (iw_byte == r_csum) begin
                                r_done <= 1'b1;
                                r_hold <= 1'b0;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed and random frames compared against a
// frame-level model of expected memory writes, pulses and core hold.
module tb_imem_loader;

    logic        iw_clk = 1'b0;
    logic        iw_rst_n = 1'b1;
    logic [7:0]  iw_byte = 8'h00;
    logic        iw_byte_valid = 1'b0;
    logic        iw_abort = 1'b0;
    logic        ow_byte_ready;
    logic        ow_mem_we;
    logic [23:0] ow_mem_addr;
    logic [23:0] ow_mem_wdata;
    logic        ow_cpu_hold;
    logic        ow_done;
    logic        ow_err;
    logic        or_busy;

    int          checks = 0;
    int          errors = 0;
    int          doneCnt = 0;
    int          errCnt = 0;
    logic [47:0] obsQ[$];
    logic [23:0] wordsQ[$];
    logic [23:0] lastAddr = '0;
    logic [23:0] lastData = '0;

    imem_loader #(.DATA_W(24), .ADDR_W(24)) dut (
        .iw_clk        (iw_clk),
        .iw_rst_n      (iw_rst_n),
        .iw_byte       (iw_byte),
        .iw_byte_valid (iw_byte_valid),
        .ow_byte_ready (ow_byte_ready),
        .iw_abort      (iw_abort),
        .ow_mem_we     (ow_mem_we),
        .ow_mem_addr   (ow_mem_addr),
        .ow_mem_wdata  (ow_mem_wdata),
        .ow_cpu_hold   (ow_cpu_hold),
        .ow_done       (ow_done),
        .ow_err        (ow_err),
        .or_busy       (or_busy)
    );

    always #5 iw_clk = ~iw_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Passive monitor: records writes and pulses, and checks the write port holds when idle
    always @(negedge iw_clk) begin
        #1;
        if (!iw_rst_n) begin
            lastAddr = '0;
            lastData = '0;
        end else begin
            checkOutput("doneErrExclusive", 64'(ow_done & ow_err), 64'd0);
            if (ow_mem_we) begin
                obsQ.push_back({ow_mem_addr, ow_mem_wdata});
                lastAddr = ow_mem_addr;
                lastData = ow_mem_wdata;
            end else begin
                checkOutput("addrHold", 64'(ow_mem_addr), 64'(lastAddr));
                checkOutput("dataHold", 64'(ow_mem_wdata), 64'(lastData));
            end
            if (ow_done) doneCnt++;
            if (ow_err) errCnt++;
        end
    end

    // Offers one byte, occasionally after an idle gap, and holds it until accepted
    task automatic applyStimulus(input logic [7:0] b);
        int guard = 0;
        bit sent = 1'b0;
        if ($urandom_range(3) == 0) begin
            iw_byte_valid = 1'b0;
            @(negedge iw_clk);
        end
        iw_byte = b;
        iw_byte_valid = 1'b1;
        while (!sent && guard < 20) begin
            #1;
            sent = ow_byte_ready;
            @(negedge iw_clk);
            guard++;
        end
        iw_byte_valid = 1'b0;
        checkOutput("byteAccepted", 64'(sent), 64'd1);
    endtask

    task automatic runFrame(input string tag, input logic [23:0] startAddr, input bit badSum,
                            input bit sendJunk, input logic [7:0] junkByte);
        logic [7:0]  body[$];
        logic [47:0] expQ[$];
        logic [7:0]  sum;
        int          n;
        int          nCmp;
        n = wordsQ.size();
        obsQ.delete();
        doneCnt = 0;
        errCnt = 0;
        if (sendJunk) begin
            applyStimulus(junkByte);
            checkOutput({tag, "_junkDropped"}, 64'(or_busy), 64'd0);
        end
        body.push_back(startAddr[23:16]);
        body.push_back(startAddr[15:8]);
        body.push_back(startAddr[7:0]);
        body.push_back(8'(n >> 8));
        body.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            body.push_back(wordsQ[i][23:16]);
            body.push_back(wordsQ[i][15:8]);
            body.push_back(wordsQ[i][7:0]);
            expQ.push_back({startAddr + 24'(i), wordsQ[i]});
        end
        sum = 8'd0;
        foreach (body[i]) sum = sum + body[i];
        applyStimulus(8'hA5);
        checkOutput({tag, "_holdOnSync"}, 64'(ow_cpu_hold), 64'd1);
        checkOutput({tag, "_busyOnSync"}, 64'(or_busy), 64'd1);
        foreach (body[i]) applyStimulus(body[i]);
        applyStimulus(badSum ? sum + 8'd1 : sum);
        repeat (3) @(negedge iw_clk);
        checkOutput({tag, "_writeCount"}, 64'(obsQ.size()), 64'(n));
        nCmp = (obsQ.size() < n) ? obsQ.size() : n;
        for (int i = 0; i < nCmp; i++) checkOutput({tag, "_write"}, 64'(obsQ[i]), 64'(expQ[i]));
        checkOutput({tag, "_doneCount"}, 64'(doneCnt), 64'(!badSum));
        checkOutput({tag, "_errCount"}, 64'(errCnt), 64'(badSum));
        checkOutput({tag, "_holdAfter"}, 64'(ow_cpu_hold), 64'(badSum));
        checkOutput({tag, "_busyAfter"}, 64'(or_busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [23:0] a;
        #1 iw_rst_n = 1'b0;
        #1;
        checkOutput("rstReady", 64'(ow_byte_ready), 64'd0);
        checkOutput("rstHold", 64'(ow_cpu_hold), 64'd1);
        checkOutput("rstWe", 64'(ow_mem_we), 64'd0);
        checkOutput("rstBusy", 64'(or_busy), 64'd0);
        checkOutput("rstDone", 64'(ow_done), 64'd0);
        checkOutput("rstErr", 64'(ow_err), 64'd0);
        checkOutput("rstAddr", 64'(ow_mem_addr), 64'd0);
        checkOutput("rstData", 64'(ow_mem_wdata), 64'd0);
        repeat (3) @(negedge iw_clk);
        iw_rst_n = 1'b1;
        @(negedge iw_clk);
        checkOutput("readyAfterRst", 64'(ow_byte_ready), 64'd1);

        wordsQ = '{24'h112233, 24'h445566};
        runFrame("goodFrame", 24'h000010, 1'b0, 1'b0, 8'h00);
        runFrame("badSum", 24'h000010, 1'b1, 1'b0, 8'h00);
        wordsQ = '{24'h010203, 24'h040506};
        runFrame("addrWrap", 24'hFFFFFF, 1'b0, 1'b0, 8'h00);
        wordsQ.delete();
        runFrame("zeroWords", 24'h000000, 1'b0, 1'b1, 8'h3C);

        // Abort coincident with the last byte of the first word
        obsQ.delete();
        doneCnt = 0;
        errCnt = 0;
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h20);
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        iw_byte = 8'h33;
        iw_byte_valid = 1'b1;
        iw_abort = 1'b1;
        @(negedge iw_clk);
        iw_abort = 1'b0;
        iw_byte_valid = 1'b0;
        #1;
        checkOutput("abortErrPulse", 64'(ow_err), 64'd1);
        checkOutput("abortBusy", 64'(or_busy), 64'd0);
        checkOutput("abortHold", 64'(ow_cpu_hold), 64'd1);
        repeat (2) @(negedge iw_clk);
        checkOutput("abortNoWrite", 64'(obsQ.size()), 64'd0);
        checkOutput("abortErrCount", 64'(errCnt), 64'd1);
        checkOutput("abortNoDone", 64'(doneCnt), 64'd0);
        wordsQ = '{24'hABCDEF, 24'h123456, 24'h789ABC};
        runFrame("afterAbort", 24'h000020, 1'b0, 1'b0, 8'h00);

        // Abort while the word is being written
        obsQ.delete();
        errCnt = 0;
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h30);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        applyStimulus(8'hCC);
        iw_abort = 1'b1;
        #1;
        checkOutput("writeAbortWe", 64'(ow_mem_we), 64'd0);
        @(negedge iw_clk);
        iw_abort = 1'b0;
        #1;
        checkOutput("writeAbortErr", 64'(ow_err), 64'd1);
        repeat (2) @(negedge iw_clk);
        checkOutput("writeAbortNoWrite", 64'(obsQ.size()), 64'd0);
        checkOutput("writeAbortBusy", 64'(or_busy), 64'd0);

        // Abort while idle has no effect
        errCnt = 0;
        iw_abort = 1'b1;
        @(negedge iw_clk);
        iw_abort = 1'b0;
        repeat (2) @(negedge iw_clk);
        checkOutput("idleAbortIgnored", 64'(errCnt), 64'd0);

        // Reset in the middle of the count field
        obsQ.delete();
        errCnt = 0;
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h40);
        applyStimulus(8'h00);
        iw_rst_n = 1'b0;
        #1;
        checkOutput("midRstReady", 64'(ow_byte_ready), 64'd0);
        checkOutput("midRstHold", 64'(ow_cpu_hold), 64'd1);
        checkOutput("midRstBusy", 64'(or_busy), 64'd0);
        checkOutput("midRstErr", 64'(ow_err), 64'd0);
        checkOutput("midRstAddr", 64'(ow_mem_addr), 64'd0);
        checkOutput("midRstData", 64'(ow_mem_wdata), 64'd0);
        repeat (2) @(negedge iw_clk);
        iw_rst_n = 1'b1;
        @(negedge iw_clk);
        checkOutput("midRstReadyBack", 64'(ow_byte_ready), 64'd1);
        checkOutput("midRstNoErr", 64'(errCnt), 64'd0);
        checkOutput("midRstNoWrite", 64'(obsQ.size()), 64'd0);
        wordsQ = '{24'h0F0F0F, 24'hF0F0F0};
        runFrame("afterRst", 24'h000050, 1'b0, 1'b0, 8'h00);

        for (int f = 0; f < 12; f++) begin
            logic [7:0] junk;
            a = 24'($urandom);
            if ($urandom_range(3) == 0) a = 24'hFFFFFF - 24'($urandom_range(2));
            wordsQ.delete();
            for (int w = 0; w < $urandom_range(5); w++) wordsQ.push_back(24'($urandom));
            junk = 8'($urandom);
            if (junk == 8'hA5) junk = 8'h5A;
            runFrame("random", a, ($urandom_range(3) == 0), ($urandom_range(1) == 1), junk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
